// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte-stream requesters.
// Optional build macro UART_TX_ARB_HDR_EN prefixes every grant with a header byte {4'hA, grant_id}.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WORD_SIZE = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_ready,
  output logic                          send_valid,
  output logic [WORD_SIZE-1:0]          data_bits,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);

`ifdef UART_TX_ARB_HDR_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_ISSUE, S_DRAIN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DRAIN} state_t;
`endif

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_q, rr_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic                 last_q, last_d;
  logic [BW-1:0]        burst_q, burst_d;
`ifdef UART_TX_ARB_HDR_EN
  // Marks that the byte in ISSUE/DRAIN is the header, not payload.
  logic                 hdr_q, hdr_d;
`endif

  logic                 win_found;
  logic [IDW-1:0]       win_id;
  logic [IDW-1:0]       next_ptr;

  assign next_ptr = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      burst_q <= '0;
`ifdef UART_TX_ARB_HDR_EN
      hdr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      burst_q <= burst_d;
`ifdef UART_TX_ARB_HDR_EN
      hdr_q   <= hdr_d;
`endif
    end
  end

  // Scan starts at rr_q and wraps, so the first valid index found is the fair winner.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    hold_d     = hold_q;
    last_d     = last_q;
    burst_d    = burst_q;
`ifdef UART_TX_ARB_HDR_EN
    hdr_d      = hdr_q;
`endif
    req_ready  = '0;
    send_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_id;
          burst_d = '0;
`ifdef UART_TX_ARB_HDR_EN
          state_d = S_HDR;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      S_HDR: begin
        hold_d  = WORD_SIZE'({4'hA, 4'(grant_q)});
        hdr_d   = 1'b1;
        state_d = S_ISSUE;
      end
`endif
      S_FETCH: begin
        if (req_valid[grant_q]) begin
          req_ready[grant_q] = 1'b1;
          hold_d  = req_data[grant_q*WORD_SIZE +: WORD_SIZE];
          last_d  = req_last[grant_q];
          burst_d = burst_q + BW'(1);
          state_d = S_ISSUE;
        end else begin
          rr_d    = next_ptr;
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        send_valid = tx_ready;
        if (tx_ready) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // tx_ready is low on the first DRAIN cycle; returning high means the byte is out.
        if (tx_ready) begin
`ifdef UART_TX_ARB_HDR_EN
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = S_FETCH;
          end else
`endif
          if (last_q || burst_q == BW'(MAX_BURST)) begin
            rr_d    = next_ptr;
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_bits = hold_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a transmitter
// stub goes busy for 10 cycles per byte, and a monitor pops expected {grant_id, byte} pairs.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk;
  logic           rstn;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_ready;
  logic           send_valid;
  logic [W-1:0]   data_bits;
  logic [1:0]     grant_id;
  logic           busy;

  uart_tx_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_ready(tx_ready), .send_valid(send_valid), .data_bits(data_bits),
    .grant_id(grant_id), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  logic [8:0] rq [N][$];
  logic [9:0] sbq[$];
  int         rdy_cnt[N];
  int         tx_cnt = 0;
  logic       prev_sv = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter stub: idle until it accepts a byte, then busy for 10 cycles.
  always @(posedge clk) begin
    if (send_valid) tx_cnt <= 10;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_ready = (tx_cnt == 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d);
    logic [1:0] id2;
    id2 = id[1:0];
    sbq.push_back({id2, d});
  endtask

  task automatic exp_grant(input int id);
`ifdef UART_TX_ARB_HDR_EN
    logic [7:0] h;
    h = 8'hA0 | 8'(id);
    expect_byte(id, h);
`endif
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Driver: pops a requester's byte when the DUT accepted it on the preceding edge.
  initial begin
    logic [N-1:0] rdy;
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    drive_inputs();
    forever begin
      @(posedge clk);
      rdy = req_ready;
      #1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] && rq[i].size() > 0) begin
          void'(rq[i].pop_front());
          rdy_cnt[i]++;
        end
      end
      drive_inputs();
    end
  end

  // Monitor: every transmitted byte must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rstn) begin
      if (send_valid) begin
        chk("send_valid_gap", {31'd0, prev_sv}, 32'd0);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_send actual=0x%0h required=none", {grant_id, data_bits});
        end else begin
          e = sbq.pop_front();
          chk("send_byte", {22'd0, grant_id, data_bits}, {22'd0, e});
        end
      end
      if (req_ready != '0)
        chk("req_ready_legal", {31'd0, ($onehot(req_ready) && ((req_ready & ~req_valid) == '0))}, 32'd1);
    end
    prev_sv = rstn && send_valid;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_send_valid"}, {31'd0, send_valid}, 32'd0);
    chk({tag, "_req_ready"},  {28'd0, req_ready}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy}, 32'd0);
    chk({tag, "_grant_id"},   {30'd0, grant_id}, 32'd0);
    chk({tag, "_data_bits"},  {24'd0, data_bits}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(sbq.size() == 0 && !busy && all_empty()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=busy%0d required=idle", nm, busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_grant(input string nm, input logic [1:0] id);
    int n;
    n = 0;
    while (!(busy && grant_id == id) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", nm, grant_id, id);
    end
  endtask

  initial begin
    int n;
    int r2;
    rstn = 1'b1;
    drive_inputs();
    #3 rstn = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Single one-byte message from req0; afterwards rr_ptr=1 so req1 beats req0.
    push(0, 8'h55, 1'b1); exp_grant(0); expect_byte(0, 8'h55);
    wait_idle("t1");
    chk("t1_ready_pulses", rdy_cnt[0], 1);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    push(0, 8'h01, 1'b1); push(1, 8'h02, 1'b1);
    exp_grant(1); expect_byte(1, 8'h02); exp_grant(0); expect_byte(0, 8'h01);
    wait_idle("t1b");

    // After reset: 0 then 2 (rr=3); again 0 then 2 (scan wraps 3->0); then 3 before 2.
    do_reset();
    push(0, 8'hA0, 1'b1); push(2, 8'hA2, 1'b1);
    exp_grant(0); expect_byte(0, 8'hA0); exp_grant(2); expect_byte(2, 8'hA2);
    wait_idle("t2a");
    push(0, 8'hB0, 1'b1); push(2, 8'hB2, 1'b1);
    exp_grant(0); expect_byte(0, 8'hB0); exp_grant(2); expect_byte(2, 8'hB2);
    wait_idle("t2b");
    push(2, 8'hC2, 1'b1); push(3, 8'hC3, 1'b1);
    exp_grant(3); expect_byte(3, 8'hC3); exp_grant(2); expect_byte(2, 8'hC2);
    wait_idle("t2c");

    // Three-byte message from req1 is not preempted by req3.
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    exp_grant(1); expect_byte(1, 8'h11); expect_byte(1, 8'h22); expect_byte(1, 8'h33);
    wait_grant("t3_grant", 2'd1);
    push(3, 8'h3C, 1'b1); exp_grant(3); expect_byte(3, 8'h3C);
    wait_idle("t3");

    // MAX_BURST=4 forces a release after 4 bytes of an unterminated stream.
    for (int i = 0; i < 6; i++) push(0, 8'hD1 + 8'(i), 1'b0);
    push(1, 8'h1F, 1'b1);
    exp_grant(0);
    for (int i = 0; i < 4; i++) expect_byte(0, 8'hD1 + 8'(i));
    exp_grant(1); expect_byte(1, 8'h1F);
    exp_grant(0); expect_byte(0, 8'hD5); expect_byte(0, 8'hD6);
    wait_idle("t4");

    // req2 withdraws its byte once granted: release without any payload byte.
    r2 = rdy_cnt[2];
    push(2, 8'h99, 1'b1); exp_grant(2);
    wait_grant("t5_grant", 2'd2);
    #1;
    rq[2].delete();
    drive_inputs();
    wait_idle("t5a");
    chk("t5_no_ready_req2", rdy_cnt[2] - r2, 0);

    // Reset during DRAIN aborts req1's message; req0 then wins from rr_ptr=0.
    push(1, 8'h5A, 1'b0); push(1, 8'h5B, 1'b1);
    exp_grant(1); expect_byte(1, 8'h5A);
    n = 0;
    while (!(send_valid && data_bits == 8'h5A) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL t5_send_timeout actual=%0d required=send", n);
    end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("drain_reset");
    push(0, 8'h0C, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    exp_grant(0); expect_byte(0, 8'h0C); exp_grant(1); expect_byte(1, 8'h5B);
    wait_idle("t5b");

`ifdef UART_TX_ARB_HDR_EN
    // Header 0xA2 precedes the payload; req_ready fires only for the payload capture.
    r2 = rdy_cnt[2];
    push(2, 8'h7E, 1'b1); exp_grant(2); expect_byte(2, 8'h7E);
    wait_idle("t6");
    chk("t6_ready_pulses", rdy_cnt[2] - r2, 1);
`endif

    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
